decode_stage: RTL



---
 rtl/decode_stage.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: comb decode into a 2-entry skid buffer with registered in_ready.
// Optional `DECODE_ILLEGAL_EN adds an `illegal` bundle output for unsupported encodings.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      op_select,
  output logic            alt_operator,
  output logic            branch_mode,
  output logic            use_imm,
  output logic [1:0]      op1_sel,
  output logic            operand_swap,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic [1:0]      jump,
`ifdef DECODE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] pc_out
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [2:0]      op_select;
    logic            alt_operator;
    logic            branch_mode;
    logic            use_imm;
    logic [1:0]      op1_sel;
    logic            operand_swap;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic [1:0]      jump;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
    logic [XLEN-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  bundle_t     dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef DECODE_ILLEGAL_EN
  logic ill;

  always_comb begin
    ill = 1'b0;
    case (opcode)
      OP_R: ill = !(instr[31:25] == 7'h00 || instr[31:25] == 7'h20);
      OP_I: ill = (funct3 == 3'b001 && instr[31:25] != 7'h00) ||
                  (funct3 == 3'b101 && !(instr[31:25] == 7'h00 || instr[31:25] == 7'h20));
      OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: ill = 1'b0;
      default: ill = 1'b1;
    endcase
  end
`endif

  always_comb begin
    dec     = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    dec.pc  = pc;
    case (opcode)
      OP_R: begin
        dec.op_select    = funct3;
        dec.alt_operator = instr[30];
        dec.reg_write    = 1'b1;
      end
      OP_I: begin
        dec.op_select    = funct3;
        dec.alt_operator = (funct3 == 3'b101) ? instr[30] : 1'b0;
        dec.use_imm      = 1'b1;
        // shifts and SLT/SLTU feed the immediate through op1 of the ALU
        dec.operand_swap = (funct3 == 3'b001) || (funct3 == 3'b101) ||
                           (funct3 == 3'b010) || (funct3 == 3'b011);
        dec.imm          = XLEN'($signed(imm_i));
        dec.reg_write    = 1'b1;
      end
      OP_B: begin
        dec.branch_mode = 1'b1;
        dec.op_select   = funct3;
        dec.imm         = XLEN'($signed(imm_b));
      end
      OP_LUI: begin
        dec.op1_sel   = 2'b10;
        dec.use_imm   = 1'b1;
        dec.imm       = XLEN'($signed(imm_u));
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.op1_sel   = 2'b01;
        dec.use_imm   = 1'b1;
        dec.imm       = XLEN'($signed(imm_u));
        dec.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec.jump      = 2'b01;
        dec.imm       = XLEN'($signed(imm_j));
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.jump      = 2'b10;
        dec.use_imm   = 1'b1;
        dec.imm       = XLEN'($signed(imm_i));
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    if (ill) begin
      dec         = '0;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      dec.pc      = pc;
      dec.illegal = 1'b1;
    end
`endif
  end

  occ_t    state_q, state_d;
  bundle_t head_q, head_d, skid_q, skid_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_d  = dec;
          state_d = ONE;
        end
        ONE: begin
          if (accept && !pop) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (accept && pop) begin
            head_d = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign op_select    = head_q.op_select;
  assign alt_operator = head_q.alt_operator;
  assign branch_mode  = head_q.branch_mode;
  assign use_imm      = head_q.use_imm;
  assign op1_sel      = head_q.op1_sel;
  assign operand_swap = head_q.operand_swap;
  assign imm          = head_q.imm;
  assign rs1          = head_q.rs1;
  assign rs2          = head_q.rs2;
  assign rd           = head_q.rd;
  assign reg_write    = head_q.reg_write;
  assign jump         = head_q.jump;
`ifdef DECODE_ILLEGAL_EN
  assign illegal      = head_q.illegal;
`endif
  assign pc_out       = head_q.pc;

endmodule
